ctrl_pipe: RTL and testbench

Pipelined control unit for the 16-bit, 4-bit-opcode processor. It decodes the ID-stage opcode into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, injects bubbles on stall and on branch flush, and drains the pipeline on HLT. It sits between the IF/ID register and the datapath stages and replaces the ad-hoc per-stage control decoding.

---
 rtl/ctrl_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control unit for the 16-bit, 4-bit-opcode pipelined processor.
// It decodes the ID-stage opcode into a control bundle, then carries that
// bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects
// load-use hazards, inserts bubbles on a stall or a branch flush, and drains
// the pipeline after HLT.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset
//   id_valid                 IF/ID holds a real instruction
//   id_opcode/rs/rt/rd       ID-stage fields (rs carries rd for LLB/LHB,
//                            rt carries the data register for SW)
//   ex_branch_taken          branch resolved taken in EX; flush ID
//   id_branch                combinational: B/BR is in ID
//   id_stall                 combinational: hold PC and IF/ID this cycle
//   ex_*                     ID/EX control bundle
//   mem_*                    EX/MEM control bundle
//   wb_*                     MEM/WB control bundle
//   halted                   registered: processor halted
module ctrl_pipe #(
  parameter int REG_AW    = 4,
  parameter int ALUOP_W   = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [3:0]         id_opcode,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_branch_taken,
  output logic               id_branch,
  output logic               id_stall,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic [1:0]         ex_memtoreg,
  output logic               ex_regwrite,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic [1:0]         mem_memtoreg,
  output logic               mem_regwrite,
  output logic [REG_AW-1:0]  mem_rd,
  output logic [1:0]         wb_memtoreg,
  output logic               wb_regwrite,
  output logic [REG_AW-1:0]  wb_rd,
  output logic               halted
);

  // Control bundles. Each stage keeps only the fields that the later stages
  // still use.
  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic [1:0]         memtoreg;
    logic               regwrite;
    logic [REG_AW-1:0]  rd;
  } idex_t;

  typedef struct packed {
    logic              memread;
    logic              memwrite;
    logic [1:0]        memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic [1:0]        memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  idex_t  idex_q, idex_d, dec;
  exmem_t exmem_q;
  memwb_t memwb_q;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic halted_q;

  logic rs_used, rt_used, hazard, is_hlt, hlt_acc;

  // Decode. B, BR and HLT leave every control bit at zero.
  always_comb begin
    dec    = '0;
    dec.rd = id_rd;
    case (id_opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        dec.aluop    = ALUOP_W'(id_opcode);
        dec.regwrite = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        dec.aluop    = ALUOP_W'(id_opcode);
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_LW: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 2'd1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_SW: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_LLB: begin
        dec.aluop    = ALUOP_W'(4'h9);
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_LHB: begin
        dec.aluop    = ALUOP_W'(4'h8);
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      OP_PCS: begin
        dec.memtoreg = 2'd2;
        dec.regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rs_used = (id_opcode <= OP_LHB) || (id_opcode == OP_BR);
    rt_used = (id_opcode <= 4'h3) || (id_opcode == 4'h7) || (id_opcode == OP_SW);
  end

  // Load-use: a load in EX writes a register that the instruction in ID
  // reads. Register 0 always reads as zero, so it never creates a hazard.
  assign hazard = HAZARD_EN && idex_q.memread && idex_q.regwrite &&
                  (idex_q.rd != '0) && id_valid &&
                  ((rs_used && (idex_q.rd == id_rs)) ||
                   (rt_used && (idex_q.rd == id_rt)));

  assign is_hlt  = id_valid && (id_opcode == OP_HLT);
  // A HLT in ID is discarded when the branch ahead of it is taken.
  assign hlt_acc = is_hlt && !ex_branch_taken && (state_q == RUN) && !hazard;

  assign id_branch = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR));
  assign id_stall  = ((state_q != RUN) && !ex_branch_taken) ||
                     (hazard && !ex_branch_taken) ||
                     (is_hlt && !ex_branch_taken && (state_q == RUN));

  // ID/EX load selection, in priority order.
  always_comb begin
    idex_d = '0;
    if (ex_branch_taken)       idex_d = '0;
    else if (state_q != RUN)   idex_d = '0;
    else if (hazard)           idex_d = '0;
    else if (!id_valid)        idex_d = '0;
    else if (is_hlt)           idex_d = '0;
    else                       idex_d = dec;
  end

  // Halt FSM. After HLT is accepted, the counter delays HALTED by three
  // edges so that the older instructions can retire through WB. A taken
  // branch cannot sit behind a HLT, so the FSM ignores the flush in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (hlt_acc) begin
        state_d = DRAIN;
        cnt_d   = 2'd2;
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = HALTED;
        else               cnt_d   = cnt_q - 2'd1;
      end
      HALTED: state_d = HALTED;
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q   <= '0;
      exmem_q  <= '0;
      memwb_q  <= '0;
      state_q  <= RUN;
      cnt_q    <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      idex_q           <= idex_d;
      // The stages below ID never stall.
      exmem_q.memread  <= idex_q.memread;
      exmem_q.memwrite <= idex_q.memwrite;
      exmem_q.memtoreg <= idex_q.memtoreg;
      exmem_q.regwrite <= idex_q.regwrite;
      exmem_q.rd       <= idex_q.rd;
      memwb_q.memtoreg <= exmem_q.memtoreg;
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.rd       <= exmem_q.rd;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      halted_q         <= (state_d == HALTED);
    end
  end

  assign ex_aluop     = idex_q.aluop;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_memread   = idex_q.memread;
  assign ex_memwrite  = idex_q.memwrite;
  assign ex_memtoreg  = idex_q.memtoreg;
  assign ex_regwrite  = idex_q.regwrite;
  assign ex_rd        = idex_q.rd;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign mem_memtoreg = exmem_q.memtoreg;
  assign mem_regwrite = exmem_q.regwrite;
  assign mem_rd       = exmem_q.rd;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_rd        = memwb_q.rd;
  assign halted       = halted_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe. Expected WB bundles are pushed into a queue
// when an instruction is seen entering EX, and popped two edges later.
// A second instance with HAZARD_EN=0 shares the inputs and is used only
// for the hazard-disable check.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n, id_valid, br;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;

  logic id_branch, id_stall, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite;
  logic [3:0] ex_aluop, ex_rd, mem_rd, wb_rd;
  logic [1:0] ex_memtoreg, mem_memtoreg, wb_memtoreg;
  logic mem_memread, mem_memwrite, mem_regwrite, wb_regwrite, halted;

  logic n_branch, n_stall, n_alusrc, n_memread, n_memwrite, n_regwrite;
  logic [3:0] n_aluop, n_rd, n_mrd, n_wrd;
  logic [1:0] n_m2r, n_mm2r, n_wm2r;
  logic n_mmr, n_mmw, n_mrw, n_wrw, n_halted;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(4), .ALUOP_W(4), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(br),
    .id_branch(id_branch), .id_stall(id_stall), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .halted(halted));

  ctrl_pipe #(.REG_AW(4), .ALUOP_W(4), .HAZARD_EN(1'b0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(br),
    .id_branch(n_branch), .id_stall(n_stall), .ex_aluop(n_aluop),
    .ex_alusrc(n_alusrc), .ex_memread(n_memread), .ex_memwrite(n_memwrite),
    .ex_memtoreg(n_m2r), .ex_regwrite(n_regwrite), .ex_rd(n_rd),
    .mem_memread(n_mmr), .mem_memwrite(n_mmw),
    .mem_memtoreg(n_mm2r), .mem_regwrite(n_mrw), .mem_rd(n_mrd),
    .wb_memtoreg(n_wm2r), .wb_regwrite(n_wrw), .wb_rd(n_wrd),
    .halted(n_halted));

  typedef struct {
    int         due;
    string      tag;
    logic [6:0] wb;   // {memtoreg, regwrite, rd}
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  ncmp = 0;
  int  nfail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pack all ID/EX outputs together as {aluop, alusrc, memread, memwrite, memtoreg, regwrite, rd}.
  function automatic logic [15:0] ex_all();
    return {1'b0, ex_aluop, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_rd};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic b);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; br = b;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  // One clock edge. The WB entries that are due this cycle are compared.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e = sb_q.pop_front();
      chk({e.tag, "_wb"}, {9'd0, wb_memtoreg, wb_regwrite, wb_rd}, {9'd0, e.wb});
    end
  endtask

  // An instruction has just been observed in EX; it reaches WB two edges later.
  task automatic push_wb(input string tag, input logic [1:0] m2r,
                         input logic rw, input logic [3:0] rd);
    sb_t e;
    e.due = cyc + 2; e.tag = tag; e.wb = {m2r, rw, rd};
    sb_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk("rst_ex",     ex_all(), 16'h0);
    chk("rst_mem",    {9'd0, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd}, 16'h0);
    chk("rst_wb",     {9'd0, wb_memtoreg, wb_regwrite, wb_rd}, 16'h0);
    chk("rst_halted", {15'd0, halted}, 16'h0);
    chk("rst_stall",  {15'd0, id_stall}, 16'h0);
    chk("rst_branch", {15'd0, id_branch}, 16'h0);
    rst_n = 1'b1;

    // add rd=3
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
    tick();
    chk("add_ex", ex_all(), {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h3});
    push_wb("add", 2'd0, 1'b1, 4'h3);
    idle(); tick(); tick();

    // lw rd=5, then add rs=5: one stall, and the add reaches EX one cycle late
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0);
    tick();
    chk("lw_ex", ex_all(), {1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 4'h5});
    push_wb("lw", 2'd1, 1'b1, 4'h5);
    drive(1'b1, 4'h0, 4'h5, 4'h2, 4'h6, 1'b0);
    chk("lu_stall", {15'd0, id_stall}, 16'h1);
    chk("lu_nohaz_stall", {15'd0, n_stall}, 16'h0);
    tick();
    chk("lu_bubble", ex_all(), 16'h0);
    chk("lu_nohaz_ex_rd", {12'd0, n_rd}, 16'h6);
    chk("lu_stall_clear", {15'd0, id_stall}, 16'h0);
    tick();
    chk("lu_add_ex", ex_all(), {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h6});
    push_wb("lu_add", 2'd0, 1'b1, 4'h6);
    idle(); tick();

    // lw rd=0 never causes a hazard
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h0, 1'b0);
    tick();
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h7, 1'b0);
    chk("lu_r0_stall", {15'd0, id_stall}, 16'h0);
    idle(); tick();

    // sw with rt=5 after lw rd=5
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0); tick();
    drive(1'b1, 4'h9, 4'h1, 4'h5, 4'h0, 1'b0);
    chk("sw_rt_stall", {15'd0, id_stall}, 16'h1);
    idle(); tick();
    // llb reads rs
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0); tick();
    drive(1'b1, 4'hA, 4'h5, 4'h0, 4'h5, 1'b0);
    chk("llb_rs_stall", {15'd0, id_stall}, 16'h1);
    idle(); tick();
    // llb does not read rt
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0); tick();
    drive(1'b1, 4'hA, 4'h1, 4'h5, 4'h2, 1'b0);
    chk("llb_rt_nostall", {15'd0, id_stall}, 16'h0);
    tick();
    chk("llb_ex", ex_all(), {1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'h2});
    idle(); tick(); tick();

    // Flush beats load-use
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0); tick();
    drive(1'b1, 4'h0, 4'h5, 4'h0, 4'h6, 1'b1);
    chk("flush_stall", {15'd0, id_stall}, 16'h0);
    tick();
    chk("flush_ex", ex_all(), 16'h0);
    idle(); tick(); tick();

    // Remaining decode checks
    drive(1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("b_branch", {15'd0, id_branch}, 16'h1);
    drive(1'b1, 4'hE, 4'h0, 4'h0, 4'h7, 1'b0); tick();
    chk("pcs_ex", ex_all(), {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'h7});
    push_wb("pcs", 2'd2, 1'b1, 4'h7);
    drive(1'b1, 4'hB, 4'h2, 4'h0, 4'h2, 1'b0); tick();
    chk("lhb_ex", ex_all(), {1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'h2});
    drive(1'b1, 4'h9, 4'h1, 4'h3, 4'h0, 1'b0); tick();
    chk("sw_ex", ex_all(), {1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0});
    idle(); tick(); tick();

    // add, sub, HLT, then drain to HALTED
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h1, 1'b0); tick();
    push_wb("h_add", 2'd0, 1'b1, 4'h1);
    drive(1'b1, 4'h1, 4'h1, 4'h2, 4'h2, 1'b0); tick();
    push_wb("h_sub", 2'd0, 1'b1, 4'h2);
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("hlt_stall", {15'd0, id_stall}, 16'h1);
    tick();  // HLT accepted
    chk("hlt_ex", ex_all(), 16'h0);
    chk("hlt_h0", {15'd0, halted}, 16'h0);
    tick(); chk("hlt_h1", {15'd0, halted}, 16'h0);
    tick(); chk("hlt_h2", {15'd0, halted}, 16'h0);
    tick(); chk("hlt_h3", {15'd0, halted}, 16'h1);
    chk("hlt_stall_hold", {15'd0, id_stall}, 16'h1);
    rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
    chk("hlt_rst_halted", {15'd0, halted}, 16'h0);
    chk("hlt_rst_stall", {15'd0, id_stall}, 16'h0);

    // Reset in the middle of DRAIN goes back to RUN
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0); tick(); tick();
    rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h4, 1'b0);
    chk("drain_rst_stall", {15'd0, id_stall}, 16'h0);
    tick();
    chk("drain_rst_ex", ex_all(), {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'h4});
    push_wb("post_rst", 2'd0, 1'b1, 4'h4);
    idle(); tick(); tick(); tick();
    chk("sb_empty", 16'(sb_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
